// File: rtl/des_uart_pkg.sv
// Shared constants and state types for the DES ciphertext UART transmitter.
package des_uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT    = 868;  // 100 MHz / 115200 baud
    localparam int unsigned BITS_PER_FRAME          = 10;   // start + 8 data + stop
    localparam int unsigned DEFAULT_BYTES_PER_BLOCK = 8;    // one 64-bit DES block

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } tx_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

endpackage

// File: rtl/des_uart_tx_byte.sv
// Single UART frame transmitter: start bit, 8 data bits LSB first, stop bit.
// The line is driven straight from a register so it never glitches.
module uart_tx_byte
    import des_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset2,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_FRAME - 3);

    byte_state_t   r_state;
    logic [CW-1:0] r_clk;
    logic [2:0]    r_bit;
    logic [7:0]    r_data;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end = (r_clk == LAST_CLK);

    // Frame sequencer: baud counter, bit index and registered line level.
    always_ff @(posedge clock) begin
        if (!reset2) begin
            r_state <= B_IDLE;
            r_clk   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_state)
                B_IDLE: begin
                    r_clk <= '0;
                    r_bit <= '0;
                    r_tx  <= 1'b1;
                    if (start) begin
                        r_data  <= data;
                        r_tx    <= 1'b0;
                        r_state <= B_START;
                    end
                end
                B_START: begin
                    if (w_bit_end) begin
                        r_clk   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_data[0];
                        r_state <= B_DATA;
                    end else begin
                        r_clk <= r_clk + 1'b1;
                    end
                end
                B_DATA: begin
                    if (w_bit_end) begin
                        r_clk <= '0;
                        if (r_bit == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= B_STOP;
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_data <= {1'b0, r_data[7:1]};
                            r_tx   <= r_data[1];
                        end
                    end else begin
                        r_clk <= r_clk + 1'b1;
                    end
                end
                B_STOP: begin
                    if (w_bit_end) begin
                        r_clk   <= '0;
                        r_state <= B_IDLE;
                    end else begin
                        r_clk <= r_clk + 1'b1;
                    end
                end
                default: r_state <= B_IDLE;
            endcase
        end
    end

    // byte_done marks the final cycle of the stop bit so the sequencer can
    // hand over the next byte on the very edge the stop bit ends.
    assign byte_done = (r_state == B_STOP) && w_bit_end;
    assign tx        = r_tx;

endmodule

// File: rtl/des_uart_tx.sv
// Block sequencer: accepts a ciphertext block and sends it MSB byte first as
// BYTES_PER_BLOCK UART frames, then pulses done.
module des_uart_tx
    import des_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned BYTES_PER_BLOCK = DEFAULT_BYTES_PER_BLOCK
) (
    input  logic                         clock,
    input  logic                         reset2,
    input  logic [8*BYTES_PER_BLOCK-1:0] block_in,
    input  logic                         block_valid,
    output logic                         block_ready,
    output logic                         serial_ciphertext,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned BW = 8 * BYTES_PER_BLOCK;
    localparam int unsigned LW = $clog2(BYTES_PER_BLOCK + 1);

    tx_state_t     r_state;
    logic [BW-1:0] r_shift;
    logic [LW-1:0] r_left;
    logic          r_start;
    logic [7:0]    r_data;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic          w_accept;
    logic          w_byte_done;
    logic          w_tx;

    assign w_accept = block_valid && r_ready;

    // Block FSM. The first byte is handed over at the end of LOAD, later bytes
    // on the edge the previous stop bit ends (r_start is already high on
    // entry to LOAD), so only one idle-high cycle separates frames.
    always_ff @(posedge clock) begin
        if (!reset2) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_left  <= '0;
            r_start <= 1'b0;
            r_data  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_start <= 1'b0;
                    if (w_accept) begin
                        r_shift <= block_in;
                        r_left  <= LW'(BYTES_PER_BLOCK);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (r_start) begin
                        r_start <= 1'b0;
                    end else begin
                        r_start <= 1'b1;
                        r_data  <= r_shift[BW-1 -: 8];
                        r_shift <= {r_shift[BW-9:0], 8'h00};
                        r_left  <= r_left - 1'b1;
                    end
                    r_state <= SEND;
                end
                SEND: begin
                    r_start <= 1'b0;
                    if (w_byte_done) begin
                        if (r_left != '0) begin
                            r_start <= 1'b1;
                            r_data  <= r_shift[BW-1 -: 8];
                            r_shift <= {r_shift[BW-9:0], 8'h00};
                            r_left  <= r_left - 1'b1;
                            r_state <= LOAD;
                        end else begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clock    (clock),
        .reset2   (reset2),
        .start    (r_start),
        .data     (r_data),
        .tx       (w_tx),
        .byte_done(w_byte_done)
    );

    assign block_ready       = r_ready;
    assign busy              = r_busy;
    assign done              = r_done;
    assign serial_ciphertext = w_tx;

endmodule

// File: tb/tb_des_uart_tx.sv
// Scoreboard bench for des_uart_tx: the driver pushes expected frames (byte
// value and start cycle) and done cycles; a line-decoding monitor pops them.
module tb_des_uart_tx;

    localparam int CPB   = 12;
    localparam int NB    = 8;
    localparam int FRAME = 10 * CPB;
    localparam int P     = FRAME + 1;

    logic        clock = 1'b0;
    logic        reset2 = 1'b0;
    logic [63:0] block_in = '0;
    logic        block_valid = 1'b0;
    logic        block_ready;
    logic        serial_ciphertext;
    logic        busy;
    logic        done;

    des_uart_tx #(
        .CLKS_PER_BIT   (CPB),
        .BYTES_PER_BLOCK(NB)
    ) dut (
        .clock            (clock),
        .reset2           (reset2),
        .block_in         (block_in),
        .block_valid      (block_valid),
        .block_ready      (block_ready),
        .serial_ciphertext(serial_ciphertext),
        .busy             (busy),
        .done             (done)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  b;
        int unsigned t;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned done_q[$];
    bit          mon_en = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic        fbuf[FRAME];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: frame k of a block accepted on edge e starts its start bit
    // on edge e+2+k*(10*CPB+1); done follows the last stop bit.
    task automatic expect_block(input logic [63:0] d, input int unsigned e);
        frame_t f;
        for (int k = 0; k < NB; k++) begin
            f.b = d[63-8*k -: 8];
            f.t = e + 2 + k * P;
            exp_q.push_back(f);
        end
        done_q.push_back(e + NB * P + 1);
    endtask

    task automatic send_block(input logic [63:0] d, input bit hold, output int unsigned e);
        logic r;
        bit   got;
        got = 1'b0;
        e = 0;
        block_in = d;
        block_valid = 1'b1;
        for (int i = 0; i < 3 * NB * P; i++) begin
            r = block_ready;
            tick();
            if (r === 1'b1) begin
                e = cyc;
                got = 1'b1;
                break;
            end
        end
        check("block accepted", 64'(got), 64'd1);
        if (got) expect_block(d, e);
        if (!hold) block_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3 * NB * P; i++) begin
            if (exp_q.size() == 0 && done_q.size() == 0) break;
            tick();
        end
        check("scoreboard drained", 64'(exp_q.size() + done_q.size()), 64'd0);
    endtask

    // Monitor: decodes frames from the line and checks done pulses.
    initial begin
        bit          in_frame;
        int          n;
        int unsigned fstart;
        bit          stable;
        logic [7:0]  got;
        frame_t      x;
        in_frame = 1'b0;
        n = 0;
        fstart = 0;
        forever begin
            tick();
            if (!mon_en) continue;
            if (reset2 !== 1'b1) begin
                in_frame = 1'b0;
                check("line high under reset", 64'(serial_ciphertext), 64'd1);
                check("done low under reset", 64'(done), 64'd0);
                continue;
            end
            if (done === 1'b1) begin
                check("done expected", 64'(done_q.size() != 0), 64'd1);
                check("ready in done cycle", 64'(block_ready), 64'd1);
                check("busy low in done cycle", 64'(busy), 64'd0);
                if (done_q.size() != 0) check("done cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
            if (!in_frame && serial_ciphertext !== 1'b1) begin
                in_frame = 1'b1;
                n = 0;
                fstart = cyc;
                check("busy at frame start", 64'(busy), 64'd1);
                check("ready low at frame start", 64'(block_ready), 64'd0);
            end
            if (in_frame) begin
                fbuf[n] = serial_ciphertext;
                n++;
                if (n == FRAME) begin
                    in_frame = 1'b0;
                    stable = 1'b1;
                    for (int b = 0; b < 10; b++)
                        for (int j = 0; j < CPB; j++)
                            if (fbuf[b*CPB+j] !== fbuf[b*CPB]) stable = 1'b0;
                    for (int i = 0; i < 8; i++) got[i] = fbuf[(1+i)*CPB];
                    check("bit cells hold CPB cycles", 64'(stable), 64'd1);
                    check("start bit", 64'(fbuf[0]), 64'd0);
                    check("stop bit", 64'(fbuf[9*CPB]), 64'd1);
                    check("frame expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        x = exp_q.pop_front();
                        check("frame byte", 64'(got), 64'(x.b));
                        check("frame start cycle", 64'(fstart), 64'(x.t));
                    end
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, fails so far %0d", fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e;
        int unsigned ea;
        int unsigned eb;
        int unsigned target;
        int          lows;
        logic [63:0] d;

        // Reset
        reset2 = 1'b0;
        tick();
        tick();
        check("reset line", 64'(serial_ciphertext), 64'd1);
        check("reset ready", 64'(block_ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset2 = 1'b1;
        mon_en = 1'b1;
        lows = 0;
        repeat (1000) begin
            tick();
            if (serial_ciphertext !== 1'b1) lows++;
        end
        check("idle line stays high", 64'(lows), 64'd0);

        // Single block and bit-timing patterns
        send_block(64'h1122334455667788, 1'b0, e);
        wait_drain();
        send_block(64'h55AA00FF0F0F0F0F, 1'b0, e);
        wait_drain();

        // Busy ignore: new data and valid mid-block must be ignored
        send_block(64'hA5C3_0F1E_7788_99EE, 1'b0, e);
        repeat (3 * P + 5) tick();
        block_in = {$urandom, $urandom};
        block_valid = 1'b1;
        repeat (4) begin
            tick();
            check("ready low while busy", 64'(block_ready), 64'd0);
        end
        block_valid = 1'b0;
        wait_drain();

        // Back-to-back: B accepted in A's done cycle
        send_block(64'h0123456789ABCDEF, 1'b1, ea);
        send_block(64'hFEDCBA9876543210, 1'b0, eb);
        check("B accepted in A done cycle", 64'(eb), 64'(ea + NB * P + 2));
        wait_drain();

        // Reset during bit 4 of byte 3
        send_block(64'h3C3C_5A5A_C3C3_A5A5, 1'b0, e);
        target = e + 2 + 3 * P + 5 * CPB + CPB / 2;
        for (int i = 0; i < 2 * NB * P; i++) begin
            if (cyc >= target) break;
            tick();
        end
        check("reached mid-frame point", 64'(cyc), 64'(target));
        reset2 = 1'b0;
        exp_q.delete();
        done_q.delete();
        tick();
        check("line high after reset edge", 64'(serial_ciphertext), 64'd1);
        check("ready after mid-frame reset", 64'(block_ready), 64'd1);
        check("busy after mid-frame reset", 64'(busy), 64'd0);
        reset2 = 1'b1;
        lows = 0;
        repeat (2 * P) begin
            tick();
            if (serial_ciphertext !== 1'b1 || done !== 1'b0) lows++;
        end
        check("quiet after mid-frame reset", 64'(lows), 64'd0);
        send_block(64'hDEADBEEF_CAFEF00D, 1'b0, e);
        wait_drain();

        // Randomized blocks with random idle gaps, one random back-to-back pair
        repeat (4) begin
            repeat ($urandom_range(0, 20)) tick();
            d = {$urandom, $urandom};
            send_block(d, 1'b0, e);
            wait_drain();
        end
        d = {$urandom, $urandom};
        send_block(d, 1'b1, ea);
        d = {$urandom, $urandom};
        send_block(d, 1'b0, eb);
        check("random pair back-to-back", 64'(eb), 64'(ea + NB * P + 2));
        wait_drain();

        repeat (20) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/des_uart_tx.md
Name: des_uart_tx

Overview:
- Serial output end of the DES link: accepts one 64-bit ciphertext block from the DES pipeline and transmits it as 8 UART frames on serial_ciphertext.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit CLKS_PER_BIT clocks. Matches the plaintext receive framing.
- Sits inside the top level between the DES pipeline output and the serial_ciphertext pin; raises done after the final stop bit of a block.

Parameters:
- CLKS_PER_BIT, 868, clocks per UART bit (100 MHz / 115200 baud).
- BYTES_PER_BLOCK, 8, frames per block; block width = 8*BYTES_PER_BLOCK.

Ports:
- clock  in  1  system clock; every register is updated on the rising edge.
- reset2  in  1  synchronous, active-low reset.
- block_in  in  64  ciphertext block to transmit.
- block_valid  in  1  block_in is valid.
- block_ready  out  1  high only in IDLE; a block is accepted on the edge where block_valid && block_ready.
- serial_ciphertext  out  1  UART line; idles high.
- busy  out  1  high from the cycle after acceptance until the final stop bit ends.
- done  out  1  one-cycle pulse, high in the first IDLE cycle after the last stop bit of a block.

Behaviour:
- Reset: while reset2=0 at a clock edge, the following values apply after that edge: serial_ciphertext=1, block_ready=1, busy=0, done=0. All counters are cleared, the state is IDLE, and any block in flight is discarded with no partial frame completed. Applies mid-frame too.
- Byte order: most significant byte first, so block_in[63:56] is sent first and block_in[7:0] last. Within a byte, bit 0 is sent first.
- On acceptance, block_in is latched into a shift register. Later changes to block_in have no effect.
- Top FSM states:
  - IDLE -> LOAD on accept.
  - LOAD (1 cycle): hand the next byte to the byte transmitter, then go to SEND.
  - SEND: wait for byte_done.
    - If bytes remaining > 0, go to LOAD.
    - Otherwise go to IDLE and pulse done.
- Byte transmitter FSM states:
  - B_IDLE -> B_START on start.
  - B_START (CLKS_PER_BIT cycles, line=0) -> B_DATA.
  - B_DATA (8 x CLKS_PER_BIT cycles, bit index 0..7) -> B_STOP.
  - B_STOP (CLKS_PER_BIT cycles, line=1) -> B_IDLE, pulsing byte_done.
- Timing:
  - The start bit of byte 0 appears on the line 2 cycles after the accept edge.
  - Each LOAD cycle between frames holds the line high for 1 extra cycle beyond the stop bit.
  - Every bit holds exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and wraps.
  - The bit index wraps after 7 with no off-by-one extra bit.
- Handshake:
  - block_valid is ignored while block_ready=0; there is no queueing.
  - block_ready and done are both high in the done cycle. A block presented in that cycle is accepted, giving back-to-back blocks.
- Line glitches: serial_ciphertext is driven from a register. It never glitches, and it never goes low outside a start bit or a 0 data bit.

Decomposition:
- Shared package des_uart_pkg holds:
  - default CLKS_PER_BIT (868), BITS_PER_FRAME (10), BYTES_PER_BLOCK (8);
  - typedef tx_state_t {IDLE, LOAD, SEND};
  - typedef byte_state_t {B_IDLE, B_START, B_DATA, B_STOP}.
- One sub-module, uart_tx_byte:
  - ports: clock, reset2, start, data[7:0], tx, byte_done;
  - parameter: CLKS_PER_BIT.
- des_uart_tx owns block sequencing and the handshake; uart_tx_byte owns bit timing.

Test Plan:
- Reset: hold reset2=0 for 2 edges, then release. Expect serial_ciphertext=1, block_ready=1, busy=0, done=0, and the line stays high for 1000 idle cycles.
- Single block: block_in=64'h1122334455667788 with a 1-cycle valid.
  - The decoded frames are 11,22,33,44,55,66,77,88 in order.
  - Each frame is 0,LSB..MSB,1 with 868 cycles per bit.
  - done pulses exactly once, 8*(10*868+1)+1 cycles after acceptance.
- Bit timing: block_in=64'h55AA00FF0F0F0F0F. Measure every line transition: all spacings are multiples of 868, and the LOAD gaps add exactly 1 cycle of high between frames.
- Busy ignore: change block_in and pulse block_valid mid-block. Expect block_ready=0, the output stream is unchanged, and exactly 8 frames are sent.
- Back-to-back: hold block_valid high with block A=64'h0123456789ABCDEF, then B=64'hFEDCBA9876543210 presented in the done cycle. Expect 16 frames total, B accepted in A's done cycle, and two done pulses.
- Reset mid-frame: assert reset2=0 during bit 4 of byte 3. Expect the line high after the next edge and no done pulse. A new block after release transmits correctly from byte 0.
